// File: rtl/act_buffer_mp.sv
// act_buffer_mp: banked activation buffer shared by a narrow
// port A and a wide port B, one array access per cycle.
module act_buffer_mp #(
  parameter int ADDR_W       = 18,
  parameter int WORD_W       = 8,
  parameter int NUM_BANKS    = 32,
  parameter int NARROW_BANKS = 4,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           a_req_valid,
  output logic                           a_req_ready,
  input  logic                           a_req_we,
  input  logic [ADDR_W-1:0]              a_req_addr,
  input  logic [NARROW_BANKS*WORD_W-1:0] a_req_wdata,
  input  logic [NARROW_BANKS-1:0]        a_req_be,
  output logic                           a_rsp_valid,
  output logic [NARROW_BANKS*WORD_W-1:0] a_rsp_rdata,
  input  logic                           b_req_valid,
  output logic                           b_req_ready,
  input  logic                           b_req_we,
  input  logic [ADDR_W-1:0]              b_req_addr,
  input  logic [NUM_BANKS*WORD_W-1:0]    b_req_wdata,
  input  logic [NUM_BANKS-1:0]           b_req_be,
  output logic                           b_rsp_valid,
  output logic [NUM_BANKS*WORD_W-1:0]    b_rsp_rdata
);
  localparam int NARROW_W  = NARROW_BANKS * WORD_W;
  localparam int WIDE_W    = NUM_BANKS * WORD_W;
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int NB_BITS   = $clog2(NARROW_BANKS);
  localparam int GRP_W     = BANK_BITS - NB_BITS;
  localparam int ROW_W     = ADDR_W - BANK_BITS;
  localparam int ROWS      = 1 << ROW_W;
  localparam int RATIO     = NUM_BANKS / NARROW_BANKS;
  localparam int SC_W      = $clog2(STARVE_LIMIT + 1);
  localparam int L         = RD_LAT - 1;
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  logic [WIDE_W-1:0] mem [ROWS];

  logic [ROW_W-1:0]     a_row, b_row, sel_row;
  logic [GRP_W-1:0]     a_grp;
  logic [NUM_BANKS-1:0] a_be_w, sel_be;
  logic [WIDE_W-1:0]    sel_data;
  logic                 unused_addr;

  logic a_rd, a_wr, b_rd, b_wr;
  logic any_rd, any_wr, wr_first;
  logic cand_a, cand_b, gnt_a, gnt_b;
  logic sel_we, rd_acc, wr_acc, wr_gnt;
  logic ptr_b;
  logic [SC_W-1:0] starve_q;

  logic [RD_LAT-1:0] p_vld, p_port;
  logic [GRP_W-1:0]  p_grp  [RD_LAT];
  logic [WIDE_W-1:0] p_data [RD_LAT];

  logic [NARROW_W-1:0] last_nar, a_hold;
  logic [WIDE_W-1:0]   b_hold;

  assign a_row = a_req_addr[ADDR_W-1:BANK_BITS];
  assign b_row = b_req_addr[ADDR_W-1:BANK_BITS];
  assign a_grp = a_req_addr[BANK_BITS-1:NB_BITS];
  assign unused_addr = ^{a_req_addr[NB_BITS-1:0],
                         b_req_addr[BANK_BITS-1:0]};

  // Arbitration: reads first unless a write has starved; RR within class
  always_comb begin
    a_rd     = a_req_valid && !a_req_we;
    a_wr     = a_req_valid && a_req_we;
    b_rd     = b_req_valid && !b_req_we;
    b_wr     = b_req_valid && b_req_we;
    any_rd   = a_rd || b_rd;
    any_wr   = a_wr || b_wr;
    wr_first = any_wr && (starve_q == SC_MAX);
    cand_a   = wr_first ? a_wr : (any_rd ? a_rd : a_wr);
    cand_b   = wr_first ? b_wr : (any_rd ? b_rd : b_wr);
    gnt_a    = !rst && cand_a && (!cand_b || !ptr_b);
    gnt_b    = !rst && cand_b && (!cand_a || ptr_b);
  end

  assign a_req_ready = gnt_a;
  assign b_req_ready = gnt_b;

  // Steer the granted request onto the single array access
  always_comb begin
    a_be_w   = NUM_BANKS'(a_req_be) << (32'(a_grp) * NARROW_BANKS);
    sel_we   = gnt_b ? b_req_we : a_req_we;
    sel_row  = gnt_b ? b_row : a_row;
    sel_be   = gnt_b ? b_req_be : a_be_w;
    sel_data = gnt_b ? b_req_wdata : {RATIO{a_req_wdata}};
    rd_acc   = (gnt_a || gnt_b) && !sel_we;
    wr_acc   = (gnt_a || gnt_b) && sel_we;
    wr_gnt   = wr_acc;
  end

  // Round-robin pointer and write-starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_b    <= 1'b0;
      starve_q <= '0;
    end else begin
      if (gnt_a)      ptr_b <= 1'b1;
      else if (gnt_b) ptr_b <= 1'b0;
      if (!any_wr || wr_gnt)    starve_q <= '0;
      else if (starve_q != SC_MAX) starve_q <= starve_q + 1'b1;
    end
  end

  // Per-lane masked write into the row array
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int l = 0; l < NUM_BANKS; l++) begin
        if (sel_be[l])
          mem[sel_row][l*WORD_W +: WORD_W] <= sel_data[l*WORD_W +: WORD_W];
      end
    end
  end

  // Read pipeline valid bits; cleared by reset so in-flight reads die
  always_ff @(posedge clk) begin
    if (rst) begin
      p_vld <= '0;
    end else begin
      p_vld[0] <= rd_acc;
      for (int i = 1; i < RD_LAT; i++) p_vld[i] <= p_vld[i-1];
    end
  end

  // Read pipeline payload: row data, issuing port and lane group
  always_ff @(posedge clk) begin
    p_data[0] <= mem[sel_row];
    p_port[0] <= gnt_b;
    p_grp[0]  <= a_grp;
    for (int i = 1; i < RD_LAT; i++) begin
      p_data[i] <= p_data[i-1];
      p_port[i] <= p_port[i-1];
      p_grp[i]  <= p_grp[i-1];
    end
  end

  assign last_nar = NARROW_W'(p_data[L] >> (32'(p_grp[L]) * NARROW_W));
  assign a_rsp_valid = !rst && p_vld[L] && !p_port[L];
  assign b_rsp_valid = !rst && p_vld[L] && p_port[L];
  assign a_rsp_rdata = rst ? '0 : (a_rsp_valid ? last_nar : a_hold);
  assign b_rsp_rdata = rst ? '0 : (b_rsp_valid ? p_data[L] : b_hold);

  // Hold the last response data between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      a_hold <= '0;
      b_hold <= '0;
    end else begin
      if (a_rsp_valid) a_hold <= last_nar;
      if (b_rsp_valid) b_hold <= p_data[L];
    end
  end
endmodule

// File: doc/act_buffer_mp.md
ACT_BUFFER_MP -- requirements
Module: act_buffer_mp

Interface
REQ-001 ADDR_W, 18, byte address width.
REQ-002 WORD_W, 8, bits per bank lane.
REQ-003 NUM_BANKS, 32, lanes per row; power of two; wide width NUM_BANKS*WORD_W.
REQ-004 NARROW_BANKS, 4, lanes per narrow access; power of two; divides NUM_BANKS.
REQ-005 RD_LAT, 1, cycles from read accept to response; >=1.
REQ-006 STARVE_LIMIT, 8, blocked-write cycles before writes outrank reads.
REQ-007 One clock; reset is synchronous and active-high.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 a_req_valid  input  1  narrow-port request valid.
REQ-011 a_req_ready  output  1  narrow request accepted this cycle.
REQ-012 a_req_we  input  1  1 = write, 0 = read.
REQ-013 a_req_addr  input  ADDR_W  byte address.
REQ-014 a_req_wdata  input  NARROW_BANKS*WORD_W  write data, lane 0 at LSBs.
REQ-015 a_req_be  input  NARROW_BANKS  per-lane write enable.
REQ-016 a_rsp_valid  output  1  one-cycle read-data strobe.
REQ-017 a_rsp_rdata  output  NARROW_BANKS*WORD_W  read data, held between responses.
REQ-018 b_req_valid  input  1  wide-port request valid.
REQ-019 b_req_ready  output  1  wide request accepted this cycle.
REQ-020 b_req_we  input  1  1 = write, 0 = read.
REQ-021 b_req_addr  input  ADDR_W  byte address.
REQ-022 b_req_wdata  input  NUM_BANKS*WORD_W  write data, lane 0 at LSBs.
REQ-023 b_req_be  input  NUM_BANKS  per-lane write enable.
REQ-024 b_rsp_valid  output  1  one-cycle read-data strobe.
REQ-025 b_rsp_rdata  output  NUM_BANKS*WORD_W  read data, held between responses.

Function
REQ-026 Internal array SHALL hold 2^(ADDR_W-log2(NUM_BANKS)) rows x NUM_BANKS lanes, per-lane write enable, one access per cycle.
REQ-027 Row SHALL be addr>>log2(NUM_BANKS); port B ignores bits below that.
REQ-028 Port A lane group g SHALL be addr[log2(NUM_BANKS)-1:log2(NARROW_BANKS)], lanes g*NARROW_BANKS..g*NARROW_BANKS+NARROW_BANKS-1; lower bits ignored.
REQ-029 Transfer SHALL occur on valid&&ready; requester holds valid and fields stable until ready; ready combinational, never high without valid.
REQ-030 At most one request SHALL be granted per cycle.
REQ-031 Reads SHALL beat writes, except when starve counter == STARVE_LIMIT, then a pending write beats reads.
REQ-032 Same-class contention SHALL use a round-robin pointer; after any grant pointer moves to the non-granted port.
REQ-033 Starve counter SHALL increment (saturating at STARVE_LIMIT) each cycle a write is valid but ungranted; clears on any write grant or when no write pending.
REQ-034 Accepted write SHALL update only lanes with be=1 at the accept edge; writes produce no response.
REQ-035 Read accepted the cycle after a write to the same row SHALL return the written data.
REQ-036 A RD_LAT-stage pipeline SHALL carry port id and lane group; the issuing port's rsp_valid pulses exactly RD_LAT cycles after accept, rsp_rdata updates that cycle only.
REQ-037 Reads SHALL be acceptable every cycle; responses in issue order, one per cycle.

Reset
REQ-038 While rst is high: both ready and both rsp_valid SHALL be 0; rsp_rdata cleared to 0; pointer to port A; starve counter 0; pipeline cleared, in-flight reads never respond; array contents not reset.

Verification
REQ-039 B write row 5, be all-ones, data 0x00..1F byte ramp; B read row 5 -> b_rsp_valid RD_LAT cycles later, rdata = ramp.
REQ-040 After REQ-039, A write addr 0x0A8 (row 5, g=2), data 0xDEADBEEF, be 4'b0101; B read row 5 -> lane 8 = 0xEF, lane 10 = 0xAD, all other lanes unchanged.
REQ-041 A and B read every cycle for 10 cycles -> grants alternate A,B,A,...; never two readys in one cycle; 5 in-order responses per port.
REQ-042 A write held valid while B reads every cycle (STARVE_LIMIT=8) -> a_req_ready high on 9th cycle of valid; B blocked that cycle only.
REQ-043 RD_LAT=2, A read accepted, rst high next cycle -> a_rsp_valid never pulses, a_rsp_rdata = 0.
